// File: rtl/data_mem_bytelane.sv
// Purpose: byte/half/word data memory for the load/store unit, with sign/zero
//          extended loads, misalignment errors and a sequential clear sweep.
// Latency: one cycle; the response is registered at the accept edge.
// Backpressure: req_ready is low during a clear sweep; responses cannot be stalled.
//
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   req_valid/req_ready    request handshake; accept on valid && ready
//   req_we, req_size       store/load select; size 0=byte 1=half 2=word 3=illegal
//   req_unsigned           load extension select (ignored for word loads)
//   req_addr, req_wdata    byte address, low-aligned store data
//   clear_start            starts a clear sweep when sampled in IDLE
//   busy                   clear sweep in progress
//   resp_valid/rdata/err   one-cycle response pulse; rdata/err hold between pulses
module data_mem_bytelane #(
  parameter int DEPTH_WORDS   = 128,
  parameter bit INIT_ON_RESET = 1'b1,
  localparam int ADDR_WIDTH   = $clog2(DEPTH_WORDS) + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = INIT_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       lane;
  logic             req_err;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_dat;
  logic [3:0]       st_mask;
  logic [31:0]      st_dat;

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_mask;
  logic [31:0]      mem_dat;

  // Pure state decode: ready never depends on this cycle's inputs.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign accept    = req_valid && req_ready;

  assign req_idx = req_addr[ADDR_WIDTH-1:2];
  assign lane    = req_addr[1:0];

  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // Load path: right-align the selected lane(s), then extend.
  assign rd_word = mem[req_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_dat = rd_word;
    case (req_size)
      2'd0:    load_dat = req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'd1:    load_dat = req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_dat = rd_word;
    endcase
  end

  // Store path: replicate the low-aligned data across lanes and let the
  // byte mask pick which lanes actually land.
  always_comb begin
    st_mask = 4'b0000;
    st_dat  = req_wdata;
    case (req_size)
      2'd0: begin
        st_mask = 4'b0001 << lane;
        st_dat  = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        st_dat  = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        st_mask = 4'b1111;
        st_dat  = req_wdata;
      end
      default: begin
        st_mask = 4'b0000;
        st_dat  = req_wdata;
      end
    endcase
  end

  // Single write port shared by the clear sweep and stores; the two never
  // overlap because requests are only accepted in IDLE.
  always_comb begin
    mem_we   = 1'b0;
    mem_idx  = req_idx;
    mem_mask = st_mask;
    mem_dat  = st_dat;
    if (state_q == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_idx  = clr_idx_q;
      mem_mask = 4'b1111;
      mem_dat  = 32'b0;
    end else if (accept && req_we && !req_err) begin
      mem_we = 1'b1;
    end
  end

  // Storage has no reset; holding reset must not disturb its contents.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_dat[8*b +: 8];
        end
      end
    end
  end

  // Next-state: clear_start is honoured even when a request is accepted in
  // the same cycle, so that request completes and the sweep follows it.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Response: data/err only update on an accept so they hold between pulses.
  always_comb begin
    resp_valid_d = accept;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    if (accept) begin
      resp_err_d   = req_err;
      resp_rdata_d = (req_err || req_we) ? 32'b0 : load_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_STATE;
      clr_idx_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Purpose: directed self-checking bench for data_mem_bytelane (DEPTH_WORDS=128).
// Latency: checks responses one cycle after each accept edge.
// Backpressure: exercises requests held while the clear sweep keeps ready low.
module tb_data_mem_bytelane;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [8:0]  req_addr = 9'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        clear_start = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_bytelane #(
    .DEPTH_WORDS  (128),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .clear_start (clear_start),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns,
                     input logic [8:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [8:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  // Counts edges until ready rises (bounded), tallying response pulses and
  // cycles where busy and ready fail to be complementary.
  task automatic count_sweep(output int n, output int rv, output int bad);
    n = 0; rv = 0; bad = 0;
    while (!req_ready && n < 400) begin
      step();
      n++;
      if (resp_valid) rv++;
      if (busy === req_ready) bad++;
    end
  endtask

  initial begin
    int n, rv, bad;

    // Reset state
    #1 reset = 1'b1;
    step(); step();
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 1);
    check("rst_req_ready", req_ready, 0);
    reset = 1'b0;

    // Initial sweep length
    count_sweep(n, rv, bad);
    check("init_sweep_edges", n, 128);
    check("init_sweep_resp", rv, 0);
    check("init_sweep_busy_ready", bad, 0);
    check("idle_busy", busy, 0);

    // Back-to-back vector table (memory starts all zero)
    add(0, 2'd2, 0, 9'h1FC, 32'h0,        32'h00000000, 0);
    add(1, 2'd2, 0, 9'h010, 32'hDEADBEEF, 32'h00000000, 0);
    add(0, 2'd0, 0, 9'h010, 32'h0,        32'hFFFFFFEF, 0);
    add(0, 2'd0, 0, 9'h011, 32'h0,        32'hFFFFFFBE, 0);
    add(0, 2'd0, 0, 9'h012, 32'h0,        32'hFFFFFFAD, 0);
    add(0, 2'd0, 0, 9'h013, 32'h0,        32'hFFFFFFDE, 0);
    add(0, 2'd0, 1, 9'h013, 32'h0,        32'h000000DE, 0);
    add(0, 2'd1, 1, 9'h012, 32'h0,        32'h0000DEAD, 0);
    add(0, 2'd1, 0, 9'h012, 32'h0,        32'hFFFFDEAD, 0);
    add(1, 2'd1, 0, 9'h012, 32'hFFFF1234, 32'h00000000, 0);
    add(0, 2'd2, 0, 9'h010, 32'h0,        32'h1234BEEF, 0);
    add(0, 2'd1, 0, 9'h010, 32'h0,        32'hFFFFBEEF, 0);
    add(0, 2'd2, 1, 9'h010, 32'h0,        32'h1234BEEF, 0);
    add(1, 2'd2, 0, 9'h022, 32'h11111111, 32'h00000000, 1);
    add(0, 2'd2, 0, 9'h020, 32'h0,        32'h00000000, 0);
    add(0, 2'd1, 0, 9'h011, 32'h0,        32'h00000000, 1);
    add(0, 2'd3, 0, 9'h010, 32'h0,        32'h00000000, 1);
    add(1, 2'd3, 0, 9'h014, 32'hFFFFFFFF, 32'h00000000, 1);
    add(0, 2'd2, 0, 9'h014, 32'h0,        32'h00000000, 0);
    add(1, 2'd0, 0, 9'h1FD, 32'hAAAAAA7F, 32'h00000000, 0);
    add(0, 2'd2, 0, 9'h1FC, 32'h0,        32'h00007F00, 0);
    add(0, 2'd0, 0, 9'h1FD, 32'h0,        32'h0000007F, 0);

    for (int i = 0; i < vq.size(); i++) begin
      check($sformatf("vec%0d_ready", i), req_ready, 1);
      set_req(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata);
      step();
      check($sformatf("vec%0d_valid", i), resp_valid, 1);
      check($sformatf("vec%0d_rdata", i), resp_rdata, vq[i].exp_rdata);
      check($sformatf("vec%0d_err", i), resp_err, vq[i].exp_err);
    end
    req_valid = 1'b0;
    step();
    check("hold_valid_low", resp_valid, 0);
    check("hold_rdata", resp_rdata, 32'h0000007F);
    check("hold_err", resp_err, 0);

    // Runtime clear with a store in the same cycle, then a load held through the sweep
    set_req(1, 2'd2, 0, 9'h040, 32'hA5A5A5A5);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check("rtclr_store_valid", resp_valid, 1);
    check("rtclr_store_err", resp_err, 0);
    check("rtclr_store_rdata", resp_rdata, 0);
    check("rtclr_busy", busy, 1);
    check("rtclr_ready", req_ready, 0);
    set_req(0, 2'd2, 0, 9'h040, 32'h0);
    count_sweep(n, rv, bad);
    check("rtclr_sweep_edges", n, 128);
    check("rtclr_held_req_no_resp", rv, 0);
    check("rtclr_busy_ready", bad, 0);
    step();
    req_valid = 1'b0;
    check("rtclr_load_valid", resp_valid, 1);
    check("rtclr_load_rdata", resp_rdata, 0);
    check("rtclr_load_err", resp_err, 0);

    // Reset during an in-flight response
    set_req(1, 2'd2, 0, 9'h030, 32'hCAFEF00D);
    step();
    set_req(0, 2'd2, 0, 9'h030, 32'h0);
    step();
    req_valid = 1'b0;
    check("pre_rst_valid", resp_valid, 1);
    check("pre_rst_rdata", resp_rdata, 32'hCAFEF00D);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_rdata", resp_rdata, 0);
    check("async_rst_busy", busy, 1);
    step(); step(); step();
    reset = 1'b0;
    count_sweep(n, rv, bad);
    check("rst1_sweep_edges", n, 128);
    check("rst1_sweep_resp", rv, 0);

    // Reset at sweep edge 60, held 3 cycles
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int e = 0; e < 60; e++) step();
    check("mid_sweep_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_sweep_rst_valid", resp_valid, 0);
    step(); step(); step();
    reset = 1'b0;
    count_sweep(n, rv, bad);
    check("rst2_sweep_edges", n, 128);
    check("rst2_busy_ready", bad, 0);

    // Sweep wiped earlier stores
    set_req(0, 2'd2, 0, 9'h1FC, 32'h0);
    step();
    check("wipe_1fc", resp_rdata, 0);
    set_req(0, 2'd2, 0, 9'h010, 32'h0);
    step();
    req_valid = 1'b0;
    check("wipe_010", resp_rdata, 0);
    check("wipe_010_valid", resp_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_bytelane.md
Name: data_mem_bytelane

Overview:
- Parametrised successor to the CPU's word-only data memory. Adds byte, halfword and word loads/stores, load sign/zero extension and misalignment error reporting.
- Uses a valid/ready request handshake with a registered one-cycle response.
- Replaces the single-cycle whole-array reset clear with a sequential clear sweep that can also be triggered at runtime.
- Sits between the CPU datapath load/store unit and on-chip RAM.

Parameters:
- DEPTH_WORDS, 128: number of 32-bit words. Must be a power of 2 and at least 2.
- INIT_ON_RESET, 1: 1 = run the clear sweep after reset; 0 = enter IDLE directly, with memory contents undefined.
- ADDR_WIDTH, $clog2(DEPTH_WORDS)+2: byte-address width. Derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, low-aligned
- clear_start  in  1  pulse; starts a clear sweep when sampled in IDLE
- busy  out  1  clear sweep in progress
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request

Behaviour:
- Reset values:
  - state = CLEAR if INIT_ON_RESET else IDLE
  - clr_idx = 0
  - resp_valid = 0, resp_rdata = 0, resp_err = 0
  - The memory array is not touched by reset itself.
- States:
  - CLEAR: each clock edge writes 0 to mem[clr_idx] and increments clr_idx. The edge that writes DEPTH_WORDS-1 moves to IDLE and resets clr_idx to 0.
  - IDLE: clear_start=1 moves to CLEAR at the next edge.
- busy = (state==CLEAR). req_ready = (state==IDLE); it is a registered state decode with no combinational dependence on inputs.
- Clear sweep length is exactly DEPTH_WORDS edges. req_ready first rises after the DEPTH_WORDS-th edge following reset release.
- Accept rule: a request is accepted on an edge with req_valid && req_ready. The block accepts up to one request per cycle, back-to-back. No request is accepted in CLEAR. req_valid held during CLEAR waits and is not dropped by the block.
- clear_start and an accepted request in the same IDLE cycle: the request completes normally and the sweep starts on the next cycle, so a store in that cycle is subsequently wiped.
- Response timing:
  - resp_valid = 1 on the cycle after acceptance, for exactly one cycle.
  - Response has no backpressure.
  - resp_* other than resp_valid hold their last values when resp_valid = 0.
- Addressing: word index = req_addr[ADDR_WIDTH-1:2]; lane = req_addr[1:0]. No out-of-range case exists.
- Errors: resp_err = 1, resp_rdata = 0 and no memory write in each of these cases:
  - size 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
- Stores, written at the accept edge:
  - byte: writes lane addr[1:0] with wdata[7:0]
  - half: writes bytes {addr[1],1} and {addr[1],0} with wdata[15:0]
  - word: writes the full word
  - Unwritten lanes are preserved.
  - Store response: rdata = 0, err = 0.
- Loads:
  - The word is read at the accept edge and registered.
  - The selected byte or half is right-aligned, then sign-extended (req_unsigned = 0) or zero-extended (req_unsigned = 1).
  - Word loads ignore req_unsigned.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Reset asserted mid-sweep or mid-response:
  - Immediately returns to the reset state. resp_valid drops asynchronously.
  - The sweep restarts from index 0 after release.
  - An in-flight response is lost.

Test Plan:
- Reset release with INIT_ON_RESET=1 and DEPTH_WORDS=128 -> busy=1 and req_ready=0 for exactly 128 edges, then busy=0 and req_ready=1. A word load at 0x1FC returns 0x00000000.
- Store word 0xDEADBEEF @0x010, then byte loads @0x010..0x013 back-to-back -> responses on consecutive cycles:
  - signed: 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE
  - unsigned @0x013: 0x000000DE
- Store half 0x1234 @0x012 over 0xDEADBEEF -> word load @0x010 = 0x1234BEEF. Signed half load @0x010 = 0xFFFFBEEF.
- Misaligned requests:
  - word store @0x022 -> resp_err=1, resp_rdata=0, and a subsequent load @0x020 is unchanged
  - half load @0x011 -> err=1
  - size=3 -> err=1
- Runtime clear: in IDLE, store 0xA5A5A5A5 @0x040 with clear_start=1 in the same cycle -> store response err=0, then busy=1 for 128 cycles. Load @0x040 afterwards = 0.
- Reset asserted at clear edge 60 and held 3 cycles -> resp_valid=0 immediately, and the sweep takes a full 128 edges after release.
